// File: rtl/dac_xy_tx_if.sv
// Valid/ready sample stream carrying one X/Y pair per transfer into dac_xy_tx.
interface dac_xy_tx_if #(
    parameter int DATA_BITS = 10
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_BITS-1:0] s_x;
    logic [DATA_BITS-1:0] s_y;

    modport master (output s_valid, s_x, s_y, input s_ready);
    modport slave  (input s_valid, s_x, s_y, output s_ready);
endinterface

// File: rtl/dac_xy_tx.sv
// Paced XY DAC transmitter: small sample FIFO drained at one pair per CLK_DIV clocks.
// Optional build macro DAC_XY_TX_BLANK_ON_UNDERFLOW_EN parks both buses at midscale on underflow.
module dac_xy_tx #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_SIZE = 2,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    dac_xy_tx_if.slave           s,
    output logic [DATA_BITS-1:0] dac_x_bus,
    output logic [DATA_BITS-1:0] dac_y_bus,
    output logic                 dac_clk,
    output logic                 underflow,
    output logic                 idle
);
    localparam int DEPTH = 2 ** ADDR_SIZE;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [ADDR_SIZE:0] FULL_CNT = {1'b1, {ADDR_SIZE{1'b0}}};
`ifdef DAC_XY_TX_BLANK_ON_UNDERFLOW_EN
    localparam logic [DATA_BITS-1:0] MID = {1'b1, {(DATA_BITS-1){1'b0}}};
`endif

    logic [2*DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0]   wptr;
    logic [ADDR_SIZE-1:0]   rptr;
    logic [ADDR_SIZE:0]     count;
    logic [DIV_W-1:0]       div_cnt;
    logic [DIV_W-1:0]       div_nxt;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   tick;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign s.s_ready = !full;
    assign idle      = empty;
    assign push      = s.s_valid && !full;
    assign tick      = en && (div_cnt == DIV_LAST);
    // Pop decision uses the pre-edge count, so a same-edge push never bypasses to the buses.
    assign pop       = tick && !empty;

    always_comb begin
        div_nxt = '0;
        if (en && (div_cnt != DIV_LAST)) begin
            div_nxt = div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {s.s_x, s.s_y};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            div_cnt   <= '0;
            dac_x_bus <= '0;
            dac_y_bus <= '0;
            dac_clk   <= 1'b0;
            underflow <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            dac_clk   <= en && (div_nxt >= DIV_HALF);
            underflow <= tick && empty;

            if (push) begin
                wptr <= wptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (pop) begin
                {dac_x_bus, dac_y_bus} <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
`ifdef DAC_XY_TX_BLANK_ON_UNDERFLOW_EN
            else if (tick) begin
                dac_x_bus <= MID;
                dac_y_bus <= MID;
            end
`endif
        end
    end
endmodule
